// File: rtl/clock_pkg.sv
// Shared definitions for the wall-clock datapath: time-field widths, field
// limits and the time-setting controller's state encoding.
package clock_pkg;

  // Field widths for binary hour (0..23) and minute (0..59) values.
  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  // Largest legal value of each field; the next increment wraps to zero.
  localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(23);
  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);

  // Controller states. RUN lets the counter chain advance; the SET states
  // freeze it while the user edits; COMMIT is the one-cycle load strobe.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  // Wrap-around increment of an hour value.
  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] v);
    return (v == HR_MAX) ? '0 : v + 1'b1;
  endfunction

  // Wrap-around increment of a minute value.
  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] v);
    return (v == MIN_MAX) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: a counter running 0..BLINK_HALF-1 whose wrap toggles
// the phase bit. A clear restarts the visible (phase 0) half-period.
module blink_gen #(
  parameter int BLINK_HALF = 50
) (
  input  logic clk_100,
  input  logic rst,
  input  logic i_clr,
  output logic o_phase
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_wrap;

  assign w_wrap  = (r_cnt == CNT_LAST);
  assign o_phase = r_phase;

  // Half-period counter with phase toggle on wrap; clear forces visible phase.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: freezes the minute/hour chain while the user edits
// hours then minutes with two buttons, commits the result with a one-cycle
// load strobe, abandons the edit after a period of inactivity, and drives the
// display mux and field blinking while editing.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF = 50,
  parameter int TIMEOUT_S  = 10
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             pb_mode,
  input  logic             pb_inc,
  input  logic             tick_1hz,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic             run_en,
  output logic             load,
  output logic [HR_W-1:0]  load_hr,
  output logic [MIN_W-1:0] load_min,
  output logic [HR_W-1:0]  disp_hr,
  output logic [MIN_W-1:0] disp_min,
  output logic             blank_hr,
  output logic             blank_min,
  output logic             editing
);

  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [HR_W-1:0]  r_edit_hr;
  logic [MIN_W-1:0] r_edit_min;
  logic [IDLE_W-1:0] r_idle;

  logic w_in_set;
  logic w_activity;
  logic w_timeout;
  logic w_enter_hr;
  logic w_enter_min;
  logic w_inc_hr;
  logic w_inc_min;
  logic w_blink_clr;
  logic w_phase;

  // Event decode. pb_mode always wins over a simultaneous pb_inc.
  assign w_in_set    = (r_state == SET_HR) || (r_state == SET_MIN);
  assign w_activity  = pb_mode || pb_inc;
  assign w_timeout   = w_in_set && !w_activity && tick_1hz && (r_idle == IDLE_LAST);
  assign w_enter_hr  = (r_state == RUN) && pb_mode;
  assign w_enter_min = (r_state == SET_HR) && pb_mode;
  assign w_inc_hr    = (r_state == SET_HR) && pb_inc && !pb_mode;
  assign w_inc_min   = (r_state == SET_MIN) && pb_inc && !pb_mode;
  assign w_blink_clr = w_enter_hr || w_enter_min || w_inc_hr || w_inc_min;

  // Next-state logic; COMMIT always returns to RUN after its single cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (pb_mode) w_state_next = SET_HR;
      end
      SET_HR: begin
        if (pb_mode)        w_state_next = SET_MIN;
        else if (w_timeout) w_state_next = RUN;
      end
      SET_MIN: begin
        if (pb_mode)        w_state_next = COMMIT;
        else if (w_timeout) w_state_next = RUN;
      end
      COMMIT: begin
        w_state_next = RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Edit registers: snapshot the running time on entry, then step the active field.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      r_edit_hr  <= '0;
      r_edit_min <= '0;
    end else if (w_enter_hr) begin
      r_edit_hr  <= cur_hr;
      r_edit_min <= cur_min;
    end else begin
      if (w_inc_hr)  r_edit_hr  <= hr_inc(r_edit_hr);
      if (w_inc_min) r_edit_min <= min_inc(r_edit_min);
    end
  end

  // Inactivity counter: counts seconds in the SET states, restarts on any press.
  // It is held at zero outside the SET states so each edit starts fresh.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (!w_in_set || w_activity) begin
      r_idle <= '0;
    end else if (tick_1hz) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk_100 (clk_100),
    .rst     (rst),
    .i_clr   (w_blink_clr),
    .o_phase (w_phase)
  );

  // Outputs decoded from registered state only; the display mux is the one
  // path from inputs (cur_*) to outputs, selected by registered state.
  assign run_en    = (r_state == RUN);
  assign editing   = (r_state != RUN);
  assign load      = (r_state == COMMIT);
  assign load_hr   = (r_state == COMMIT) ? r_edit_hr  : '0;
  assign load_min  = (r_state == COMMIT) ? r_edit_min : '0;
  assign disp_hr   = (r_state == RUN) ? cur_hr  : r_edit_hr;
  assign disp_min  = (r_state == RUN) ? cur_min : r_edit_min;
  assign blank_hr  = (r_state == SET_HR)  && w_phase;
  assign blank_min = (r_state == SET_MIN) && w_phase;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences; expected load values are
// queued by the stimulus and checked by a monitor whenever load pulses.
module tb_time_set_ctrl;

  logic       clk_100 = 1'b0;
  logic       rst = 1'b0;
  logic       pb_mode = 1'b0;
  logic       pb_inc = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hr = 5'd13;
  logic [5:0] cur_min = 6'd45;
  logic       run_en, load, blank_hr, blank_min, editing;
  logic [4:0] load_hr, disp_hr;
  logic [5:0] load_min, disp_min;

  typedef struct {
    int hr;
    int mn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  time_set_ctrl #(
    .BLINK_HALF (50),
    .TIMEOUT_S  (10)
  ) dut (
    .clk_100   (clk_100),
    .rst       (rst),
    .pb_mode   (pb_mode),
    .pb_inc    (pb_inc),
    .tick_1hz  (tick_1hz),
    .cur_hr    (cur_hr),
    .cur_min   (cur_min),
    .run_en    (run_en),
    .load      (load),
    .load_hr   (load_hr),
    .load_min  (load_min),
    .disp_hr   (disp_hr),
    .disp_min  (disp_min),
    .blank_hr  (blank_hr),
    .blank_min (blank_min),
    .editing   (editing)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // One cycle with the given one-cycle pulses; returns 1 time unit after the edge.
  task automatic pulse(input logic m, input logic i, input logic t);
    pb_mode  = m;
    pb_inc   = i;
    tick_1hz = t;
    @(posedge clk_100);
    #1;
    pb_mode  = 1'b0;
    pb_inc   = 1'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  // Monitor: every load pulse must match the next queued expectation.
  always @(negedge clk_100) begin
    if (load === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got load_hr=%0d load_min=%0d expected no load",
                 load_hr, load_min);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("load_hr", int'(load_hr), e.hr);
        chk("load_min", int'(load_min), e.mn);
      end
    end
  end

  initial begin
    // Reset asserted: outputs at reset values.
    @(posedge clk_100);
    #1;
    chk("rst_run_en", int'(run_en), 1);
    chk("rst_load", int'(load), 0);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);
    chk("idle_run_en", int'(run_en), 1);
    chk("idle_load", int'(load), 0);
    chk("idle_disp_hr", int'(disp_hr), 13);
    chk("idle_disp_min", int'(disp_min), 45);
    chk("idle_blank", int'({blank_hr, blank_min}), 0);
    chk("idle_editing", int'(editing), 0);

    // pb_inc in RUN is ignored.
    pulse(0, 1, 0);
    chk("run_inc_ignored", int'(editing), 0);

    // Full edit 13:45 -> 16:47.
    pulse(1, 0, 0);
    chk("seth_run_en", int'(run_en), 0);
    chk("seth_editing", int'(editing), 1);
    cur_hr = 5'd2;
    #1;
    chk("seth_disp_snapshot", int'(disp_hr), 13);
    repeat (3) pulse(0, 1, 0);
    chk("seth_disp_hr_16", int'(disp_hr), 16);
    pulse(1, 0, 0);
    repeat (2) pulse(0, 1, 0);
    chk("setm_disp_min_47", int'(disp_min), 47);
    chk("setm_disp_hr_16", int'(disp_hr), 16);
    exp_q.push_back('{hr: 16, mn: 47});
    pulse(1, 0, 0);
    chk("commit_load", int'(load), 1);
    chk("commit_run_en", int'(run_en), 0);
    wait_cyc(1);
    chk("after_commit_load", int'(load), 0);
    chk("after_commit_run_en", int'(run_en), 1);

    // Wrap both fields from 23:59.
    cur_hr  = 5'd23;
    cur_min = 6'd59;
    wait_cyc(2);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk("wrap_disp_hr", int'(disp_hr), 0);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk("wrap_disp_min", int'(disp_min), 0);
    exp_q.push_back('{hr: 0, mn: 0});
    pulse(1, 0, 0);
    wait_cyc(2);

    // Timeout in SET_MIN after 10 ticks, no load.
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    cur_hr  = 5'd7;
    cur_min = 6'd30;
    for (int i = 0; i < 9; i++) begin
      pulse(0, 0, 1);
      wait_cyc(2);
    end
    chk("tmo_still_editing_9", int'(editing), 1);
    pulse(0, 0, 1);
    chk("tmo_editing", int'(editing), 0);
    chk("tmo_run_en", int'(run_en), 1);
    chk("tmo_disp_hr", int'(disp_hr), 7);
    wait_cyc(3);

    // Blink in SET_HR, restart on pb_inc.
    pulse(1, 0, 0);
    chk("blink_start_visible", int'(blank_hr), 0);
    wait_cyc(49);
    chk("blink_49_visible", int'(blank_hr), 0);
    wait_cyc(1);
    chk("blink_50_blank", int'(blank_hr), 1);
    chk("blink_min_not_blank", int'(blank_min), 0);
    wait_cyc(10);
    pulse(0, 1, 0);
    chk("blink_inc_visible", int'(blank_hr), 0);
    chk("blink_inc_disp_hr", int'(disp_hr), 8);
    wait_cyc(49);
    chk("blink_inc_49_visible", int'(blank_hr), 0);
    wait_cyc(1);
    chk("blink_inc_50_blank", int'(blank_hr), 1);

    // Simultaneous mode+inc: advance to SET_MIN, hour unchanged.
    pulse(1, 1, 0);
    chk("simul_disp_hr", int'(disp_hr), 8);
    chk("simul_blank_hr", int'(blank_hr), 0);
    pulse(0, 1, 0);
    chk("simul_setm_inc", int'(disp_min), 31);
    chk("simul_disp_hr_kept", int'(disp_hr), 8);

    // Asynchronous reset mid-blink in SET_MIN.
    wait_cyc(55);
    chk("setm_blank_min", int'(blank_min), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_run_en", int'(run_en), 1);
    chk("arst_editing", int'(editing), 0);
    chk("arst_blank_min", int'(blank_min), 0);
    chk("arst_load", int'(load), 0);
    chk("arst_disp_min", int'(disp_min), 30);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(5);
    chk("post_rst_run_en", int'(run_en), 1);
    chk("pending_loads", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
